// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core-side memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned AddrWDef = 32;
  localparam int unsigned DataWDef = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/mem_arb_select.sv
// Grant selection between fetch and LSU. MEM_ARB_RR_EN selects round-robin (with its
// priority pointer); otherwise fixed priority, LSU over fetch.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic if_valid,
  input  logic ls_valid,
  input  logic flush,
  input  logic advance,
  output logic gnt_if,
  output logic gnt_ls
);

  // A taken branch makes the pending fetch request stale.
  logic if_elig;
  assign if_elig = if_valid & ~flush;

`ifdef MEM_ARB_RR_EN
  logic rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (advance) begin
      rr_d = gnt_if ? OWN_LS : OWN_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q <= OWN_IF;
    end else begin
      rr_q <= rr_d;
    end
  end

  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (if_elig && ls_valid) begin
      gnt_if = (rr_q == OWN_IF);
      gnt_ls = (rr_q == OWN_LS);
    end else begin
      gnt_if = if_elig;
      gnt_ls = ls_valid;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, reset, advance};

  assign gnt_ls = ls_valid;
  assign gnt_if = if_elig & ~ls_valid;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and LSU, one transaction outstanding at a time.
// Arbitration policy is set by MEM_ARB_RR_EN (see mem_arb_select).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned DATA_W = DataWDef
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_valid,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_rvalid,
  input  logic                if_rready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  input  logic                ls_valid,
  output logic                ls_ready,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_rvalid,
  input  logic                ls_rready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_valid,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  output logic                mem_rready
);

  localparam int unsigned StrbW = DATA_W / 8;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               drop_q, drop_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [StrbW-1:0]   wstrb_q, wstrb_d;

  logic gnt_if, gnt_ls, idle, accept, resp_drop;

  assign idle   = (state_q == StIdle);
  // Readies are held low while reset is asserted so nothing is accepted during reset.
  assign accept = idle & reset & (gnt_if | gnt_ls);

  mem_arb_select u_select (
    .clk      (clk),
    .reset    (reset),
    .if_valid (if_valid),
    .ls_valid (ls_valid),
    .flush    (flush),
    .advance  (accept),
    .gnt_if   (gnt_if),
    .gnt_ls   (gnt_ls)
  );

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_wstrb = wstrb_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      owner_q <= OWN_IF;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StReq;
      StReq:   if (mem_ready) state_d = StResp;
      StResp:  if (mem_rvalid && mem_rready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture and drop tracking.
  always_comb begin
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    wstrb_d = wstrb_q;
    if (accept) begin
      owner_d = gnt_ls ? OWN_LS : OWN_IF;
      addr_d  = gnt_ls ? ls_addr : if_addr;
      wdata_d = gnt_ls ? ls_wdata : '0;
      we_d    = gnt_ls & ls_we;
      wstrb_d = gnt_ls ? ls_wstrb : '0;
    end

    drop_d = drop_q;
    if (state_d == StIdle) begin
      drop_d = 1'b0;
    end else if (flush && !idle && owner_q == OWN_IF) begin
      drop_d = 1'b1;
    end
  end

  // A flush arriving together with the response still kills it.
  assign resp_drop = drop_q | flush;

  always_comb begin
    if_ready   = idle & reset & gnt_if;
    ls_ready   = idle & reset & gnt_ls;
    mem_valid  = (state_q == StReq);
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    ls_rvalid  = 1'b0;
    ls_rdata   = '0;
    mem_rready = 1'b0;
    if (state_q == StResp) begin
      if (owner_q == OWN_LS) begin
        ls_rvalid  = mem_rvalid;
        ls_rdata   = mem_rdata;
        mem_rready = ls_rready;
      end else if (resp_drop) begin
        mem_rready = 1'b1;
      end else begin
        if_rvalid  = mem_rvalid;
        if_rdata   = mem_rdata;
        mem_rready = if_rready;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [31:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, if_ready, if_rvalid, if_rready;
  logic        ls_we, ls_valid, ls_ready, ls_rvalid, ls_rready;
  logic [3:0]  ls_wstrb, mem_wstrb;
  logic        mem_we, mem_valid, mem_ready, mem_rvalid, mem_rready;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .if_addr    (if_addr),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_rdata   (if_rdata),
    .if_rvalid  (if_rvalid),
    .if_rready  (if_rready),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_we      (ls_we),
    .ls_wstrb   (ls_wstrb),
    .ls_valid   (ls_valid),
    .ls_ready   (ls_ready),
    .ls_rdata   (ls_rdata),
    .ls_rvalid  (ls_rvalid),
    .ls_rready  (ls_rready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_wstrb  (mem_wstrb),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_rready (mem_rready)
  );

  typedef struct {
    logic        iv, lv, fl, mr, rv;
    logic        ifr, lsr, mv;
    logic [31:0] addr;
    logic        we, ifrv, lsrv, mrr;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, lv, fl, mr, rv, ifr, lsr, mv,
                              input logic [31:0] addr, input logic we, ifrv, lsrv, mrr,
                              input logic [31:0] rd);
    vec_t v;
    v.iv = iv; v.lv = lv; v.fl = fl; v.mr = mr; v.rv = rv;
    v.ifr = ifr; v.lsr = lsr; v.mv = mv; v.addr = addr; v.we = we;
    v.ifrv = ifrv; v.lsrv = lsrv; v.mrr = mrr; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] la;
    logic        lw;

    reset = 1'b0; flush = 1'b0;
    if_addr = 32'h100; if_valid = 1'b1; if_rready = 1'b1;
    ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF; ls_we = 1'b1; ls_wstrb = 4'hF;
    ls_valid = 1'b1; ls_rready = 1'b1;
    mem_ready = 1'b0; mem_rdata = 32'h13; mem_rvalid = 1'b0;

    // Table: fixed-priority or round-robin contention, then single fetch and IDLE flush.
`ifdef MEM_ARB_RR_EN
    for (int p = 0; p < 4; p++) begin
      la = (p == 0) ? 32'h0 : 32'h2000;
      lw = (p != 0);
      vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, la, lw, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 32'h100, 0, 1, 0, 1, 32'h13));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 32'h100, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 32'h2000, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 32'h2000, 1, 0, 1, 1, 0));
    end
    la = 32'h2000; lw = 1'b1;
`else
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 32'h2000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 32'h2000, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 32'h2000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h100, 0, 1, 0, 1, 32'h13));
    la = 32'h100; lw = 1'b0;
`endif
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, la, lw, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h100, 0, 1, 0, 1, 32'h13));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 32'h100, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h100, 0, 1, 0, 1, 32'h13));

    // Reset phase: no ready while reset is low, reset values once released.
    next_cyc();
    next_cyc();
    #1;
    chk("rst_if_ready", if_ready, 0);
    chk("rst_ls_ready", ls_ready, 0);
    if_valid = 1'b0; ls_valid = 1'b0; reset = 1'b1;
    next_cyc();
    #2;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_rready", mem_rready, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_rvalids", {if_rvalid, ls_rvalid}, 0);

    foreach (vecs[i]) begin
      if_valid = vecs[i].iv; ls_valid = vecs[i].lv; flush = vecs[i].fl;
      mem_ready = vecs[i].mr; mem_rvalid = vecs[i].rv;
      #2;
      chk($sformatf("v%0d_if_ready", i), if_ready, vecs[i].ifr);
      chk($sformatf("v%0d_ls_ready", i), ls_ready, vecs[i].lsr);
      chk($sformatf("v%0d_mem_valid", i), mem_valid, vecs[i].mv);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].we);
      chk($sformatf("v%0d_if_rvalid", i), if_rvalid, vecs[i].ifrv);
      chk($sformatf("v%0d_ls_rvalid", i), ls_rvalid, vecs[i].lsrv);
      chk($sformatf("v%0d_mem_rready", i), mem_rready, vecs[i].mrr);
      if (vecs[i].ifrv) chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].rd);
      if (vecs[i].mv) begin
        chk($sformatf("v%0d_mem_wstrb", i), mem_wstrb, vecs[i].we ? 4'hF : 4'h0);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].we ? 32'hDEADBEEF : 32'h0);
      end
      next_cyc();
    end
    if_valid = 1'b0; ls_valid = 1'b0; flush = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;

    // Backpressure on request, then on response.
    if_addr = 32'h300; if_valid = 1'b1;
    #2 chk("bp_accept", if_ready, 1);
    next_cyc();
    if_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk($sformatf("bp_mv%0d", k), mem_valid, 1);
      chk($sformatf("bp_addr%0d", k), mem_addr, 32'h300);
      next_cyc();
    end
    mem_ready = 1'b1;
    #2 chk("bp_mv_last", mem_valid, 1);
    next_cyc();
    mem_ready = 1'b0; mem_rvalid = 1'b1; if_rready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("bp_mrr%0d", k), mem_rready, 0);
      chk($sformatf("bp_rv%0d", k), if_rvalid, 1);
      next_cyc();
    end
    if_rready = 1'b1;
    #2 chk("bp_mrr_go", mem_rready, 1);
    next_cyc();
    mem_rvalid = 1'b0;
    #2 chk("bp_done_rv", if_rvalid, 0);

    // Flush while the fetch is in REQ.
    if_addr = 32'h200; if_valid = 1'b1;
    #1 chk("fl_accept", if_ready, 1);
    next_cyc();
    if_valid = 1'b0; flush = 1'b1;
    #2;
    chk("fl_mv", mem_valid, 1);
    chk("fl_addr", mem_addr, 32'h200);
    next_cyc();
    flush = 1'b0; mem_ready = 1'b1;
    #2 chk("fl_mv_hold", mem_valid, 1);
    next_cyc();
    mem_ready = 1'b0; mem_rvalid = 1'b1;
    #2;
    chk("fl_if_rvalid", if_rvalid, 0);
    chk("fl_mrr", mem_rready, 1);
    next_cyc();
    mem_rvalid = 1'b0; if_addr = 32'h400; if_valid = 1'b1;
    #2 chk("fl_next_accept", if_ready, 1);
    next_cyc();
    if_valid = 1'b0; mem_ready = 1'b1;
    #2 chk("fl_next_addr", mem_addr, 32'h400);
    next_cyc();
    mem_ready = 1'b0; mem_rvalid = 1'b1;
    #2 chk("fl_next_rvalid", if_rvalid, 1);
    next_cyc();
    mem_rvalid = 1'b0;

    // Flush coincident with the fetch response.
    if_valid = 1'b1;
    next_cyc();
    if_valid = 1'b0; mem_ready = 1'b1;
    next_cyc();
    mem_ready = 1'b0; mem_rvalid = 1'b1; flush = 1'b1;
    #2;
    chk("flr_if_rvalid", if_rvalid, 0);
    chk("flr_mrr", mem_rready, 1);
    next_cyc();
    mem_rvalid = 1'b0; flush = 1'b0;

    // Flush does not affect an LSU transaction.
    ls_valid = 1'b1;
    #2 chk("ls_accept", ls_ready, 1);
    next_cyc();
    ls_valid = 1'b0; flush = 1'b1; mem_ready = 1'b1;
    next_cyc();
    mem_ready = 1'b0; mem_rvalid = 1'b1;
    #2;
    chk("lsfl_rvalid", ls_rvalid, 1);
    chk("lsfl_mrr", mem_rready, 1);
    next_cyc();
    mem_rvalid = 1'b0; flush = 1'b0;

    // Reset during RESP abandons the transaction; a stale response is ignored.
    if_valid = 1'b1;
    next_cyc();
    if_valid = 1'b0; mem_ready = 1'b1;
    next_cyc();
    mem_ready = 1'b0; mem_rvalid = 1'b1; if_rready = 1'b0;
    #2 chk("rr_in_resp", if_rvalid, 1);
    reset = 1'b0;
    next_cyc();
    reset = 1'b1;
    #2;
    chk("rr_mv", mem_valid, 0);
    chk("rr_if_rvalid", if_rvalid, 0);
    chk("rr_mrr", mem_rready, 0);
    chk("rr_addr", mem_addr, 0);
    chk("rr_we", mem_we, 0);
    next_cyc();
    #2;
    chk("rr_stale_mrr", mem_rready, 0);
    chk("rr_stale_rvalid", {if_rvalid, ls_rvalid}, 0);
    mem_rvalid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares the single core-side memory port between the instruction-fetch stage and the load/store unit. It accepts one request at a time from either requester over valid/ready handshakes, issues it to the memory controller, and routes the single response back to the owner. It also discards in-flight fetch responses that a taken branch invalidates. It sits between the fetch/LSU stages and the memory controller.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte strobes are DATA_W/8)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- flush  in  1  taken branch this cycle; invalidates the fetch request or response
- if_addr / if_valid / if_ready  in / in / out  ADDR_W / 1 / 1  fetch request channel
- if_rdata / if_rvalid / if_rready  out / out / in  DATA_W / 1 / 1  fetch response channel
- ls_addr / ls_wdata / ls_we / ls_wstrb  in  ADDR_W / DATA_W / 1 / DATA_W/8  LSU request payload
- ls_valid / ls_ready  in / out  1 / 1  LSU request handshake
- ls_rdata / ls_rvalid / ls_rready  out / out / in  DATA_W / 1 / 1  LSU response channel
- mem_addr / mem_wdata / mem_we / mem_wstrb  out  ADDR_W / DATA_W / 1 / DATA_W/8  memory request payload, registered
- mem_valid / mem_ready  out / in  1 / 1  memory request handshake
- mem_rdata / mem_rvalid / mem_rready  in / in / out  DATA_W / 1 / 1  memory response channel

## Operation
- FSM states: IDLE, REQ, RESP. At most one transaction is outstanding.
- IDLE: arbitrate among the valid requesters (see Configuration). In the same cycle, assert ready to the winner only. On that handshake, latch the payload and owner (fetch reads force we=0, wstrb=0), then go to REQ.
- Fetch is ineligible in any cycle with flush=1.
- REQ: mem_valid=1 with stable payload until mem_ready. Once asserted, mem_valid is never withdrawn. On mem_ready, go to RESP.
- RESP: the response passes through combinationally to the owner: owner_rvalid=mem_rvalid, owner_rdata=mem_rdata, mem_rready=owner_rready. On the mem_rvalid & mem_rready handshake, go to IDLE.
- Every request, writes included, receives exactly one response. Write rdata is don't-care.
- Drop flag: set when flush=1 while the owner is fetch in REQ or RESP. The memory transaction still completes.
- In RESP with drop set: mem_rready=1, if_rvalid=0, and the response is discarded. The flag clears on return to IDLE.
- flush has no effect on LSU transactions.
- A mem_rvalid arriving outside RESP is a protocol error. Ignore it and hold mem_rready=0.

## Timing
- Reset values: state=IDLE, if_ready=ls_ready=0, if_rvalid=ls_rvalid=0, mem_valid=0, mem_rready=0, mem_addr/wdata/wstrb=0, mem_we=0, drop=0, RR pointer=fetch.
- Request accepted in cycle N: mem_valid=1 from N+1.
- With mem_ready at N+1 and mem_rvalid at N+2, the owner sees rvalid at N+2 and the FSM is in IDLE at N+3.
- Peak throughput is one transaction per 3 cycles.
- Ready outputs are combinational from IDLE state and the valids. Response outputs are combinational pass-through.
- Reset asserted mid-transaction abandons it. No response is delivered afterwards, and the memory controller is reset by the same reset.
- Simultaneous flush and mem_rvalid in RESP (fetch owner): the response is dropped.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. After each granted transaction, priority passes to the other requester.
- MEM_ARB_RR_EN undefined: fixed priority, LSU over fetch. No pointer register is built.

## Structure
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE=2'd0, REQ=2'd1, RESP=2'd2)
  - owner constants (OWN_IF=1'b0, OWN_LS=1'b1)
  - default widths
- One sub-module, mem_arb_select: combinational grant from if_valid, ls_valid, flush and the RR pointer. It contains the only code affected by MEM_ARB_RR_EN.

## Test plan
- Single fetch: if_addr=0x100, memory ready immediately, rdata=0x00000013. Expect mem_valid at N+1, if_rvalid/if_rdata=0x13 at N+2, IDLE at N+3.
- Contention: both valid in the same cycle, ls_addr=0x2000 write wdata=0xDEADBEEF wstrb=0xF. Expect:
  - fixed priority: LSU granted first, fetch next;
  - MEM_ARB_RR_EN after reset: fetch first, then LSU, and the grant alternates over 4 back-to-back pairs.
- Backpressure: mem_ready low for 5 cycles. Expect mem_valid and mem_addr stable throughout. Then if_rready low for 3 cycles with mem_rvalid high: expect mem_rready=0 and no state change.
- Flush in flight: fetch 0x200 in REQ, flush pulse. Expect the transaction to complete, if_rvalid never asserted, mem_rready=1 on the response, and a new fetch 0x400 accepted in the next IDLE.
- Flush with if_valid in IDLE and LSU idle: expect if_ready=0 in that cycle and acceptance in the following cycle.
- Reset low during RESP: expect all outputs at reset values on the next edge, and a stale mem_rvalid afterwards ignored.
